mode4_adder_tree_ctrl: RTL and testbench
========================================

# mode4_adder_tree_ctrl

Sequencing controller for the 4-input pipelined floating-point adder tree used in the softmax datapath. It owns the tree's three stage-enable strobes and its clear, accepts a run of 4-element input beats through a valid/ready handshake, and tracks each beat through the two-level reduction and the accumulating adder. It pulses `done` once the accumulated sum of all beats is stable on the tree output. It sits between the softmax top-level sequencer, which issues `start` and the beat count, and the adder-tree instance.

## Interface
- `CNT_WIDTH`, default 8: width of the beat-count request and the beat counters. Maximum run length is 2^CNT_WIDTH-1 beats.
- `clk`  in  1: clock. All state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: run request. Sampled only in IDLE.
- `num_beats`  in  CNT_WIDTH: number of 4-element beats in the run. Latched when `start` is accepted.
- `in_valid`  in  1: the upstream producer has a beat on the tree's `inp0..inp3`.
- `in_ready`  out  1: the controller accepts a beat this cycle.
- `tree_clear`  out  1: drives the tree's synchronous reset. Zeroes the stage registers and the accumulator.
- `mode4_stage2_run`  out  1: capture enable for the first-level adder pair.
- `mode4_stage1_run`  out  1: capture enable for the second-level adder.
- `mode4_stage0_run`  out  1: capture enable for the accumulator.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse. The tree output holds the final sum during this cycle.
- `beats_accepted`  out  CNT_WIDTH: number of beats accepted so far in the current run.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE. State is held in a binary-encoded register.
- IDLE:
  - `in_ready`=0.
  - On `start`=1, latch `num_beats` into `remaining`, clear `beats_accepted`, and go to CLEAR.
- CLEAR:
  - Lasts exactly 1 cycle, with `tree_clear`=1.
  - Next state is FEED if `remaining`!=0, otherwise DONE. A zero-beat run therefore reports a sum of 0.
- FEED:
  - `in_ready`=1.
  - A beat is accepted when `in_valid`&&`in_ready`. On acceptance, decrement `remaining` and increment `beats_accepted`.
  - On the accept that brings `remaining` to 0, go to DRAIN.
  - Stalls (`in_valid`=0) are allowed at any point and simply hold the state.
- DRAIN:
  - `in_ready`=0.
  - Lasts exactly 2 cycles, tracked by a 1-bit phase counter, then goes to DONE.
- DONE:
  - Lasts 1 cycle, with `done`=1.
  - Returns to IDLE. `beats_accepted` holds its value until the next `start`.
- Stage strobes are a valid shift pipe, independent of FSM state:
  - `mode4_stage2_run` = `in_valid`&&`in_ready`, combinational.
  - `v1` <= `mode4_stage2_run`; `mode4_stage1_run` = `v1`.
  - `v2` <= `v1`; `mode4_stage0_run` = `v2`.
  - Stalls therefore produce bubbles that never update the downstream registers. Each accepted beat is added to the accumulator exactly once.
- `tree_clear` = `reset` || (state==CLEAR), so the tree also clears whenever the system is held in reset.
- `start` is ignored while `busy`=1. `num_beats` is don't-care outside the IDLE->CLEAR transition.
- Reset mid-run: all state registers clear asynchronously to IDLE. `v1`, `v2`, `remaining` and `beats_accepted` clear to 0, and any partial sum is discarded.

## Timing
- Reset values:
  - `in_ready`=0, `mode4_stage2_run`=0, `mode4_stage1_run`=0, `mode4_stage0_run`=0.
  - `busy`=0, `done`=0, `beats_accepted`=0.
  - `tree_clear`=1 while `reset` is high, 0 after release (in IDLE).
- Cycle numbering: `start` is sampled high in cycle 0. CLEAR is cycle 1. FEED begins in cycle 2.
- Stage timing for a beat accepted in cycle t:
  - stage2 captures at the end of t.
  - stage1 captures at the end of t+1.
  - accumulator updates at the end of t+2.
- With the last accept in cycle L: DRAIN occupies L+1 and L+2, and `done` is in cycle L+3.
- Back-to-back run with no stalls: `done` comes in cycle N+4 after `start`. Latency from the last accept to `done` is always 3 cycles.
- Zero-beat run: `done` in cycle 2.
- Minimum spacing between runs: the next `start` can be sampled in the cycle after `done`.

## Test plan
- **Reset mid-run:** assert `reset` during FEED after 2 accepts -> all outputs take their reset values immediately (asynchronously). The next run with N=1 and inputs 1.0,2.0,3.0,4.0 gives sum 10.0, not including stale data.
- **Back-to-back, N=4:** all inputs 1.0, `in_valid` held high, `start` in cycle 0 -> `tree_clear` in cycle 1; `in_ready` high in cycles 2-5; `mode4_stage0_run` high in cycles 4-7; `done` in cycle 8; tree output = 16.0; `beats_accepted`=4.
- **Stalls, N=3:** `in_valid` pattern 1,0,0,1,0,1 from cycle 2 -> exactly 3 pulses each on `mode4_stage1_run` and `mode4_stage0_run`; `done` 3 cycles after the last accept; sum of inputs 2.0,0.5,−1.0 (each replicated ×4) equals 6.0.
- **Zero-beat run:** `start` with `num_beats`=0 -> `tree_clear` in cycle 1, `done` in cycle 2, no stage strobes, tree output 0.
- **Start while busy:** pulse `start` with `num_beats`=9 during a run with N=2 -> ignored; `done` at cycle 6 with `beats_accepted`=2.
- **Consecutive runs:** N=2 then N=1 with the second `start` in the cycle after the first `done` -> the second sum excludes the first run's accumulator, because `tree_clear` fires again.

Source files
------------

// File: rtl/mode4_adder_tree_ctrl_if.sv
// mode4_adder_tree_ctrl_if: start/beat handshake and adder-tree strobes between sequencer and controller
interface mode4_adder_tree_ctrl_if #(parameter int CNT_WIDTH = 8);
    logic                 start;
    logic [CNT_WIDTH-1:0] num_beats;
    logic                 in_valid;
    logic                 in_ready;
    logic                 tree_clear;
    logic                 mode4_stage2_run;
    logic                 mode4_stage1_run;
    logic                 mode4_stage0_run;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] beats_accepted;
    modport master (
        output start, num_beats, in_valid,
        input  in_ready, tree_clear, mode4_stage2_run, mode4_stage1_run, mode4_stage0_run,
               busy, done, beats_accepted
    );
    modport slave (
        input  start, num_beats, in_valid,
        output in_ready, tree_clear, mode4_stage2_run, mode4_stage1_run, mode4_stage0_run,
               busy, done, beats_accepted
    );
endinterface

// File: rtl/mode4_adder_tree_ctrl.sv
// mode4_adder_tree_ctrl: sequences clear, beat intake and drain of the 4-input pipelined adder tree
module mode4_adder_tree_ctrl #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mode4_adder_tree_ctrl_if.slave ctrl_if
);
    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
    logic [CNT_WIDTH-1:0] beats_q, beats_d;
    logic                 phase_q, phase_d;
    logic                 v1_q, v2_q;
    logic                 accept;
    assign accept = ctrl_if.in_valid && ctrl_if.in_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            beats_q     <= '0;
            phase_q     <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            phase_q     <= phase_d;
            v1_q        <= accept;
            v2_q        <= v1_q;
        end
    end
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        phase_d     = phase_q;
        case (state_q)
            IDLE: if (ctrl_if.start) begin
                state_d     = CLEAR;
                remaining_d = ctrl_if.num_beats;
                beats_d     = '0;
            end
            CLEAR: state_d = (remaining_q != '0) ? FEED : DONE;
            FEED: if (accept) begin
                remaining_d = remaining_q - CNT_WIDTH'(1);
                beats_d     = beats_q + CNT_WIDTH'(1);
                state_d     = (remaining_q == CNT_WIDTH'(1)) ? DRAIN : FEED;
            end
            // phase starts at 0 and toggles twice, so it is back at 0 for the next drain
            DRAIN: begin
                phase_d = ~phase_q;
                state_d = phase_q ? DONE : DRAIN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign ctrl_if.in_ready         = state_q == FEED;
    assign ctrl_if.tree_clear       = reset || state_q == CLEAR;
    assign ctrl_if.mode4_stage2_run = accept;
    assign ctrl_if.mode4_stage1_run = v1_q;
    assign ctrl_if.mode4_stage0_run = v2_q;
    assign ctrl_if.busy             = state_q != IDLE;
    assign ctrl_if.done             = state_q == DONE;
    assign ctrl_if.beats_accepted   = beats_q;
endmodule

// File: tb/tb_mode4_adder_tree_ctrl.sv
// tb_mode4_adder_tree_ctrl: drives runs through the controller and checks strobes, timing and a modelled tree sum
module tb_mode4_adder_tree_ctrl;
    localparam int CW = 8;
    logic clk = 1'b0;
    logic reset = 1'b1;
    mode4_adder_tree_ctrl_if #(.CNT_WIDTH(CW)) bus ();
    mode4_adder_tree_ctrl #(.CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .ctrl_if(bus));
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    real a[4];
    real p0 = 0.0, p1 = 0.0, q = 0.0, acc = 0.0;
    logic c_clr, c_s2, c_s1, c_s0;
    real c_a[4];

    // adder tree stand-in: strobes captured mid-cycle, applied on the rising edge
    always @(negedge clk) begin
        c_clr = bus.tree_clear;
        c_s2  = bus.mode4_stage2_run;
        c_s1  = bus.mode4_stage1_run;
        c_s0  = bus.mode4_stage0_run;
        for (int j = 0; j < 4; j++) c_a[j] = a[j];
    end
    always @(posedge clk) begin
        if (c_clr) begin
            p0 = 0.0; p1 = 0.0; q = 0.0; acc = 0.0;
        end else begin
            if (c_s0) acc = acc + q;
            if (c_s1) q = p0 + p1;
            if (c_s2) begin
                p0 = c_a[0] + c_a[1];
                p1 = c_a[2] + c_a[3];
            end
        end
    end

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_real(input string name, input real act, input real exp);
        checks++;
        if (act - exp < 1e-9 && exp - act < 1e-9) passed++;
        else $display("FAIL %s: got %f, expected %f", name, act, exp);
    endtask

    function automatic logic vbit(input logic [15:0] vp, input int c);
        if (c < 2) return 1'b0;
        if (c - 2 < 16) return vp[c-2];
        return 1'b1;
    endfunction

    function automatic int last_accept(input int n, input logic [15:0] vp);
        int k = 0;
        for (int c = 2; c < 200; c++) begin
            if (vbit(vp, c)) k++;
            if (k == n) return c;
        end
        return -1;
    endfunction

    task automatic run(input string tag, input int n, input logic [15:0] vp, input real v0, input real v1,
                       input real v2, input bit ramp, input int busy_cyc, input int exp_done, input real exp_sum);
        real  vals[3];
        int   k = 0, done_cyc = -1, last = 0, bad_rdy = 0, bad2 = 0, bad1 = 0, bad0 = 0;
        logic clr1 = 1'b0;
        logic [63:0] ea;
        vals[0] = v0; vals[1] = v1; vals[2] = v2;
        last = (n == 0) ? 0 : last_accept(n, vp);
        for (int c = 0; c < 64; c++) ea[c] = n != 0 && c >= 2 && c <= last && vbit(vp, c);
        for (int c = 0; c < 40 && done_cyc < 0; c++) begin
            @(posedge clk);
            #1;
            bus.start     = (c == 0) || (busy_cyc != 0 && c == busy_cyc);
            bus.num_beats = (c == 0) ? CW'(n) : CW'(9);
            bus.in_valid  = vbit(vp, c);
            for (int j = 0; j < 4; j++) a[j] = vals[k % 3] + (ramp ? real'(j) : 0.0);
            @(negedge clk);
            if (c == 1) clr1 = bus.tree_clear;
            if (bus.in_ready != (n != 0 && c >= 2 && c <= last)) bad_rdy++;
            if (bus.mode4_stage2_run != ea[c]) bad2++;
            if (bus.mode4_stage1_run != (c >= 1 && ea[c-1])) bad1++;
            if (bus.mode4_stage0_run != (c >= 2 && ea[c-2])) bad0++;
            if (bus.in_valid && bus.in_ready) k++;
            if (bus.done) begin
                done_cyc = c;
                check_real({tag, " sum"}, acc, exp_sum);
                check_int({tag, " beats_accepted"}, int'(bus.beats_accepted), n);
            end
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check_int({tag, " done cycle"}, done_cyc, exp_done);
        check_int({tag, " tree_clear c1"}, int'(clr1), 1);
        check_int({tag, " in_ready errs"}, bad_rdy, 0);
        check_int({tag, " stage2 errs"}, bad2, 0);
        check_int({tag, " stage1 errs"}, bad1, 0);
        check_int({tag, " stage0 errs"}, bad0, 0);
    endtask

    typedef struct {
        int          n;
        logic [15:0] vp;
        real         v0, v1, v2;
        bit          ramp;
        int          busy_cyc;
        int          exp_done;
        real         exp_sum;
    } vec_t;

    initial begin
        vec_t tbl[5];
        tbl[0] = '{4, 16'hFFFF, 1.0, 1.0, 1.0, 1'b0, 0, 8, 16.0};
        tbl[1] = '{3, 16'h0029, 2.0, 0.5, -1.0, 1'b0, 0, 10, 6.0};
        tbl[2] = '{0, 16'hFFFF, 5.0, 5.0, 5.0, 1'b0, 0, 2, 0.0};
        tbl[3] = '{2, 16'hFFFF, 1.5, 2.5, 0.0, 1'b0, 3, 6, 16.0};
        tbl[4] = '{1, 16'hFFFF, 0.25, 0.0, 0.0, 1'b0, 0, 5, 1.0};
        bus.start = 1'b0;
        bus.num_beats = '0;
        bus.in_valid = 1'b0;
        for (int j = 0; j < 4; j++) a[j] = 0.0;
        #2;
        check_int("rst tree_clear", int'(bus.tree_clear), 1);
        check_int("rst in_ready", int'(bus.in_ready), 0);
        check_int("rst busy", int'(bus.busy), 0);
        check_int("rst done", int'(bus.done), 0);
        check_int("rst beats", int'(bus.beats_accepted), 0);
        check_int("rst strobes", int'({bus.mode4_stage2_run, bus.mode4_stage1_run, bus.mode4_stage0_run}), 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1 check_int("idle tree_clear", int'(bus.tree_clear), 0);
        for (int i = 0; i < 5; i++)
            run($sformatf("vec%0d", i), tbl[i].n, tbl[i].vp, tbl[i].v0, tbl[i].v1, tbl[i].v2,
                tbl[i].ramp, tbl[i].busy_cyc, tbl[i].exp_done, tbl[i].exp_sum);
        // reset after two accepts of a five-beat run
        @(posedge clk); #1 bus.start = 1'b1; bus.num_beats = CW'(5);
        @(posedge clk); #1 bus.start = 1'b0;
        for (int j = 0; j < 4; j++) a[j] = 9.0;
        @(posedge clk); #1 bus.in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 check_int("pre-reset stage0", int'(bus.mode4_stage0_run), 1);
        reset = 1'b1;
        #1;
        check_int("midrst in_ready", int'(bus.in_ready), 0);
        check_int("midrst busy", int'(bus.busy), 0);
        check_int("midrst beats", int'(bus.beats_accepted), 0);
        check_int("midrst strobes", int'({bus.mode4_stage2_run, bus.mode4_stage1_run, bus.mode4_stage0_run}), 0);
        check_int("midrst tree_clear", int'(bus.tree_clear), 1);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b0;
        run("post-reset", 1, 16'hFFFF, 1.0, 0.0, 0.0, 1'b1, 0, 5, 10.0);
        for (int r = 0; r < 8; r++) begin
            int          n;
            logic [15:0] vp;
            real         v[3];
            real         s;
            n  = $urandom_range(0, 6);
            vp = 16'($urandom);
            for (int j = 0; j < 3; j++) v[j] = real'($urandom_range(0, 8)) * 0.5 - 2.0;
            s = 0.0;
            for (int b = 0; b < n; b++) s = s + 4.0 * v[b % 3];
            run($sformatf("rand%0d", r), n, vp, v[0], v[1], v[2], 1'b0, 0,
                (n == 0) ? 2 : last_accept(n, vp) + 3, s);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
